// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM states and master indices for mem_port_arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4096;
  localparam int M0 = 0;
  localparam int M1 = 1;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer flips to the other master after every grant
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt = enable ? ((req == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req) : 2'b00;
    ptr_d = gnt[M0] ? 1'b1 : gnt[M1] ? 1'b0 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one write port and one async read port between two masters, zero-fills memory after reset
module mem_port_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int DEPTH = mem_arb_pkg::DEPTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_dpra,
  input  logic [DATA_W-1:0] mem_dpo,
  output logic              init_done
);
  import mem_arb_pkg::*;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0] gnt;
  logic arb_en, any, wr;
  logic m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  assign arb_en = (state_q == ST_RUN) && !rst;
  rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({m1_req, m0_req}),
    .enable(arb_en),
    .gnt(gnt)
  );
  assign m0_gnt = gnt[M0];
  assign m1_gnt = gnt[M1];
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign init_done = state_q == ST_RUN;
  always_comb begin
    any = |gnt;
    sel_addr = gnt[M1] ? m1_addr : m0_addr;
    sel_wdata = gnt[M1] ? m1_wdata : m0_wdata;
    wr = gnt[M1] ? m1_we : (gnt[M0] & m0_we);
    mem_we = !rst && ((state_q == ST_INIT) || wr);
    mem_a = (state_q == ST_INIT) ? cnt_q : wr ? sel_addr : '0;
    mem_d = wr ? sel_wdata : '0;
    mem_dpra = (any && !wr) ? sel_addr : '0;
    cnt_d = (state_q == ST_INIT) ? cnt_q + ADDR_W'(1) : '0;
    state_d = ((state_q == ST_INIT) && (cnt_q == ADDR_W'(DEPTH - 1))) ? ST_RUN : state_q;
    m0_rvalid_d = gnt[M0] & ~m0_we;
    m1_rvalid_d = gnt[M1] & ~m1_we;
    m0_rdata_d = m0_rvalid_d ? mem_dpo : m0_rdata_q;
    m1_rdata_d = m1_rvalid_d ? mem_dpo : m1_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a behavioural memory/arbitration model
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4096;
  logic clk = 0;
  logic rst = 1;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, init_done;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_d, mem_dpo;
  logic [AW-1:0] mem_a, mem_dpra;
  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int turn = 0;
  logic exp_g0 = 0, exp_g1 = 0, exp_we = 0;
  logic exp_rv0 = 0, exp_rv1 = 0, nxt_rv0 = 0, nxt_rv1 = 0;
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0, nxt_rd0 = '0, nxt_rd1 = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_dpra(mem_dpra), .mem_dpo(mem_dpo),
    .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem_arr[mem_a] <= mem_d;
  assign mem_dpo = mem_arr[mem_dpra];

  // Reference: one access per cycle, a lone requester wins, ties go to whoever did not win last.
  function automatic void model();
    int w;
    w = (m0_req && m1_req) ? turn : m1_req ? 1 : m0_req ? 0 : -1;
    exp_g0 = (w == 0);
    exp_g1 = (w == 1);
    exp_we = (exp_g0 && m0_we) || (exp_g1 && m1_we);
    nxt_rv0 = exp_g0 && !m0_we;
    nxt_rv1 = exp_g1 && !m1_we;
    if (nxt_rv0) nxt_rd0 = exp_mem[m0_addr];
    if (nxt_rv1) nxt_rd1 = exp_mem[m1_addr];
    if (exp_g0 && m0_we) exp_mem[m0_addr] = m0_wdata;
    if (exp_g1 && m1_we) exp_mem[m1_addr] = m1_wdata;
    if (w >= 0) turn = 1 - w;
  endfunction

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    exp_rv0 = nxt_rv0; exp_rv1 = nxt_rv1; exp_rd0 = nxt_rd0; exp_rd1 = nxt_rd1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    model();
    #1;
  endtask

  task automatic do_reset(input int n, output int bad);
    bad = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (mem_we !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) bad++;
      @(negedge clk);
    end
    turn = 0;
    nxt_rv0 = 0; nxt_rv1 = 0; nxt_rd0 = '0; nxt_rd1 = '0;
    foreach (exp_mem[i]) exp_mem[i] = '0;
    rst = 0;
  endtask

  task automatic fill(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (mem_we !== 1'b1 || mem_a !== AW'(i) || mem_d !== '0 || m0_gnt !== 1'b0 ||
          m1_gnt !== 1'b0 || init_done !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset(3, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_quiet: %0d reset cycles with write/grant, want 0", bad); end
    checks++;
    if ({init_done, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_vals: init_done=%b rv=%b%b rd0=%h rd1=%h, want all 0", init_done, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    m0_req = 1; m0_we = 0; m0_addr = 30;
    fill(DEPTH, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill: %0d bad fill cycles, want 0", bad); end
    drive(1, 0, 30, '0, 0, 0, '0, '0);
    checks++;
    if ({init_done, m0_gnt} !== 2'b11) begin errors++; $display("FAIL first_grant: init_done=%b gnt0=%b, want 1 1", init_done, m0_gnt); end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL read30: rvalid=%b rdata=%h, want 1 00000000", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] dat [4] = '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0};
    logic [AW-1:0] adr [4] = '{12'd10, 12'd20, 12'd10, 12'd20};
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1, k < 2, adr[k], dat[k], 0, 0, '0, '0);
      else drive(0, 0, '0, '0, 0, 0, '0, '0);
      checks++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_we} !== {exp_g1, exp_g0, exp_rv1, exp_rv0, exp_we}) begin
        errors++; $display("FAIL single_ctl k=%0d: got %b want %b", k,
          {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_we}, {exp_g1, exp_g0, exp_rv1, exp_rv0, exp_we});
      end
      checks++;
      if (m0_rdata !== exp_rd0) begin errors++; $display("FAIL single_rdata k=%0d: got %h want %h", k, m0_rdata, exp_rd0); end
    end
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h12345678}) begin
      errors++; $display("FAIL single_hold: rvalid=%b rdata=%h, want 0 12345678", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_contention();
    drive(0, 0, '0, '0, 1, 0, 20, '0);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1, 0, 10, '0, 1, 0, 20, '0);
      else drive(0, 0, '0, '0, 0, 0, '0, '0);
      checks++;
      if (k < 4 && {m1_gnt, m0_gnt} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contend_order k=%0d: gnt=%b%b", k, m1_gnt, m0_gnt);
      end
      checks++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !==
          {exp_g1, exp_g0, exp_rv1, exp_rv0, exp_rd1, exp_rd0}) begin
        errors++; $display("FAIL contend k=%0d: got %b%b%b%b %h %h want %b%b%b%b %h %h", k,
          m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata, exp_g1, exp_g0, exp_rv1, exp_rv0, exp_rd1, exp_rd0);
      end
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== {32'hDEADBEEF, 32'h12345678}) begin
      errors++; $display("FAIL contend_data: rd0=%h rd1=%h, want deadbeef 12345678", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_raw();
    drive(0, 0, '0, '0, 1, 1, 12'h7FF, 32'hCAFEF00D);
    drive(1, 0, 12'h7FF, '0, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL raw: rvalid=%b rdata=%h, want 1 cafef00d", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_random();
    logic p0 = 0, p1 = 0, w0 = 0, w1 = 0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0) begin p0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 15)); d0 = $urandom; end
      if (!p1) begin p1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 15)); d1 = $urandom; end
      drive(p0, w0, a0, d0, p1, w1, a1, d1);
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_we, m1_rdata, m0_rdata} !==
          {exp_g1, exp_g0, exp_rv1, exp_rv0, exp_we, exp_rd1, exp_rd0}) begin
        bad++;
        if (bad < 5) $display("FAIL random c=%0d: got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", c,
          m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_we, m1_rdata, m0_rdata,
          exp_g1, exp_g0, exp_rv1, exp_rv0, exp_we, exp_rd1, exp_rd0);
      end
      if (exp_g0) p0 = 0;
      if (exp_g1) p1 = 0;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_total: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset(1, bad);
    fill(100, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_100: %0d bad cycles, want 0", bad); end
    do_reset(2, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_fill_reset: %0d reset cycles with write/grant", bad); end
    fill(DEPTH, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_restart: %0d bad cycles, want 0", bad); end
    drive(1, 0, 5, '0, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 0, 6, '0);
    checks++;
    if ({m1_gnt, m0_rvalid} !== 2'b11) begin errors++; $display("FAIL pre_rst: gnt1=%b rv0=%b, want 1 1", m1_gnt, m0_rvalid); end
    m1_addr = 7;
    do_reset(1, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL run_reset: %0d reset cycles with write/grant", bad); end
    checks++;
    if ({init_done, m0_rvalid, m1_rvalid} !== 3'b000) begin
      errors++; $display("FAIL run_reset_vals: init_done=%b rv=%b%b, want 000", init_done, m0_rvalid, m1_rvalid);
    end
    m1_req = 0;
    fill(DEPTH, bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_again: %0d bad cycles, want 0", bad); end
    drive(1, 0, 40, '0, 1, 0, 41, '0);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin errors++; $display("FAIL ptr_reset: gnt=%b%b, want 01", m1_gnt, m0_gnt); end
    drive(0, 0, '0, '0, 1, 0, 41, '0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL post_reset_read: rv1=%b rd1=%h, want 1 00000000", m1_rvalid, m1_rdata);
    end
  endtask

  initial begin
    foreach (mem_arr[i]) mem_arr[i] = $urandom;
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller for the 4096 x 32 dual-port data memory (`memory_wrapper`): shares its write port (`a`/`d`/`we`) and asynchronous read port (`dpra`/`dpo`) between master 0 (CPU load/store unit) and master 1 (program/debug loader). It grants at most one access per cycle using round-robin priority and registers read data. It zero-fills the whole memory after reset so that every address reads deterministically.

## Interface
- `ADDR_W`, 12, memory address width
- `DATA_W`, 32, memory data width
- `DEPTH`, 4096, number of words; the zero-fill walks 0..DEPTH-1
- `CLEAR_ON_RESET`, 1, enables the post-reset zero-fill

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `m0_req`, `m1_req` in 1: access request; held high until granted
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read; qualified by req
- `m0_addr`, `m1_addr` in ADDR_W: word address
- `m0_wdata`, `m1_wdata` in DATA_W: write data
- `m0_gnt`, `m1_gnt` out 1: combinational grant; the access completes at this clock edge
- `m0_rvalid`, `m1_rvalid` out 1: registered, 1-cycle read-data strobe
- `m0_rdata`, `m1_rdata` out DATA_W: registered read data; holds its value between reads
- `mem_a` out ADDR_W: to memory `a`
- `mem_d` out DATA_W: to memory `d`
- `mem_we` out 1: to memory `we`
- `mem_dpra` out ADDR_W: to memory `dpra`
- `mem_dpo` in DATA_W: from memory `dpo`, asynchronous read
- `init_done` out 1: high once the block is in RUN

## Operation
- States:
  - INIT: zero-fill.
  - RUN: arbitration.
- Transitions:
  - `rst` forces INIT, or RUN when `CLEAR_ON_RESET`=0.
  - INIT goes to RUN on the cycle in which the counter writes address DEPTH-1.
- INIT:
  - `mem_we`=1, `mem_a`=fill counter, `mem_d`=0.
  - Counter starts at 0 and increments by 1 per cycle.
  - Both gnt are 0, and requests stay pending.
  - Fill takes exactly DEPTH cycles.
- RUN:
  - If exactly one master requests, it is granted.
  - If both request, the master selected by the priority pointer is granted.
  - After any grant, the pointer moves to the other master. The pointer resets to master 0.
  - Granted write: `mem_a`=addr, `mem_d`=wdata, `mem_we`=1.
  - Granted read: `mem_dpra`=addr, `mem_we`=0. At the edge, `mem_dpo` is captured into that master's rdata and its rvalid is set for one cycle.
  - When there is no grant: `mem_we`=0, `mem_a`=0, `mem_d`=0, `mem_dpra`=0.
- `mem_we` is 0 in any cycle where `rst`=1.
- Only one access is made per cycle, so there is no same-cycle read/write collision. A read granted in the cycle after a write to the same address returns the new data.
- Reset during INIT restarts the fill at address 0. Reset during RUN drops any in-flight rvalid.

## Timing
- Reset values:
  - `init_done`=0, or 1 when `CLEAR_ON_RESET`=0.
  - `m0_rvalid`=`m1_rvalid`=0.
  - `m0_rdata`=`m1_rdata`=0.
  - Pointer selects m0.
  - Fill counter = 0.
- After `rst` falls, `init_done` rises DEPTH cycles later, and the first grant can occur in that same cycle.
- Grant latency is 0 cycles. A request is granted in the same cycle it is presented if it wins arbitration.
- Worst-case wait under contention is 1 cycle.
- Read latency is 1 cycle: rdata/rvalid are valid in the cycle after gnt.
- Back-to-back grants to the same master are allowed when the other master is idle.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADDR_W`, `DATA_W`, `DEPTH` defaults.
  - State enum {`ST_INIT`, `ST_RUN`}.
  - Master index constants `M0`, `M1`.
- Sub-module `rr_arbiter2`:
  - Inputs: `clk`, `rst`, `req[1:0]`, `enable`.
  - Outputs: `gnt[1:0]` (one-hot or zero).
  - Contains the pointer register and updates it only on a grant.
- The top level contains the FSM, the fill counter, the port muxing and the rdata/rvalid registers.

## Test plan
- Reset with `CLEAR_ON_RESET`=1:
  - Expect 4096 consecutive writes of 0 to addresses 0..4095.
  - Expect `init_done` high at cycle 4096 and no gnt before it.
  - Then an m0 read of address 30 returns `0x00000000` with rvalid one cycle after gnt.
- Single master:
  - m0 writes `0xDEADBEEF` to address 10 and `0x12345678` to address 20.
  - Reads of 10 and 20 return those values, one per cycle, each rvalid a 1-cycle pulse.
- Contention:
  - m0 and m1 both hold a read request from the same cycle.
  - Grants go m0, m1, m0, m1 alternately.
  - The rvalid/rdata of each master match its own address only.
- Read-after-write:
  - m1 writes `0xCAFEF00D` to address 0x7FF.
  - m0 reads 0x7FF in the next cycle and receives `0xCAFEF00D`.
- Reset mid-operation:
  - Assert `rst` during the fill at address ~100, and again during a pending m1 read.
  - Expect the fill to restart at 0, rvalid to be 0, `init_done` to be 0, and the pointer to return to m0.
